// File: rtl/vram_write_arbiter.sv
// Arbitrates the single VRAM write port between buffered CPU character writes
// and a bulk write stream, with bounded bulk bursts and an urgent CPU drain path.
module vram_write_arbiter #(
    parameter int DEPTH     = 4,
    parameter int BURST_MAX = 8,
    parameter int URGENT    = 3,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_write_address,
    input  logic [DATA_W-1:0] cpu_write_data,
    output logic              cpu_full,
    input  logic              blk_req,
    input  logic [ADDR_W-1:0] blk_waddr,
    input  logic [DATA_W-1:0] blk_wdata,
    output logic              blk_gnt,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_write_address,
    output logic [DATA_W-1:0] vram_write_data,
    output logic              busy,
    output logic              overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, BULK, CPU} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [BW-1:0]     burst_cnt, burst_nxt;
    logic              full, cpu_pend, push, cpu_gnt, bulk_gnt;
    logic              overflow_q;

    logic              vld_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
        return (v == BW'(BURST_MAX)) ? v : v + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign cpu_pend = (count != '0);
    assign push     = cpu_we && !full;

    // Grants are forced low while reset is held so the bulk engine never advances.
    always_comb begin
        state_d   = IDLE;
        cpu_gnt   = 1'b0;
        bulk_gnt  = 1'b0;
        burst_nxt = '0;
        if (rst) begin
            if (cpu_pend && blk_req) begin
                if (count >= CW'(URGENT) || burst_cnt == BW'(BURST_MAX))
                    cpu_gnt = 1'b1;
                else
                    bulk_gnt = 1'b1;
            end else if (cpu_pend) begin
                cpu_gnt = 1'b1;
            end else if (blk_req) begin
                bulk_gnt = 1'b1;
            end
            if (cpu_gnt)
                state_d = CPU;
            else if (bulk_gnt)
                state_d = BULK;
            if (bulk_gnt && cpu_pend)
                burst_nxt = sat_inc(burst_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            burst_cnt  <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (cpu_gnt)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, cpu_gnt})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            burst_cnt <= burst_nxt;
            state_q   <= state_d;
            if (cpu_we && full)
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_write_address;
            fifo_data[wr_ptr] <= cpu_write_data;
        end
    end

    // p0: select the granted write
    assign vld_p0  = cpu_gnt || bulk_gnt;
    assign addr_p0 = cpu_gnt ? fifo_addr[rd_ptr] : blk_waddr;
    assign data_p0 = cpu_gnt ? fifo_data[rd_ptr] : blk_wdata;

    // p1: registered VRAM write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign blk_gnt            = bulk_gnt;
    assign cpu_full           = full;
    assign overflow           = overflow_q;
    assign vram_we            = vld_p1;
    assign vram_write_address = addr_p1;
    assign vram_write_data    = data_p1;
    assign busy               = cpu_pend || blk_req || (state_q != IDLE);

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: default instance plus an URGENT=DEPTH
// instance so the FIFO can actually fill and drop a write.
module tb_vram_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_write_address = 16'h0;
    logic [7:0]  cpu_write_data = 8'h0;
    logic        blk_req = 1'b0;
    logic [15:0] blk_waddr = 16'h0;
    logic [7:0]  blk_wdata = 8'h0;

    logic        cpu_full, blk_gnt, vram_we, busy, overflow;
    logic [15:0] vram_write_address;
    logic [7:0]  vram_write_data;
    logic        cpu_full_b, blk_gnt_b, vram_we_b, busy_b, overflow_b;
    logic [15:0] vram_write_address_b;
    logic [7:0]  vram_write_data_b;

    int          n_chk = 0;
    int          n_pass = 0;
    int          hits;
    logic [15:0] ba;
    logic        use_b;
    logic [15:0] exp_a;

    vram_write_arbiter dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_write_address(cpu_write_address),
        .cpu_write_data(cpu_write_data), .cpu_full(cpu_full), .blk_req(blk_req),
        .blk_waddr(blk_waddr), .blk_wdata(blk_wdata), .blk_gnt(blk_gnt),
        .vram_we(vram_we), .vram_write_address(vram_write_address),
        .vram_write_data(vram_write_data), .busy(busy), .overflow(overflow)
    );

    vram_write_arbiter #(.DEPTH(4), .BURST_MAX(8), .URGENT(4)) dut_ov (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_write_address(cpu_write_address),
        .cpu_write_data(cpu_write_data), .cpu_full(cpu_full_b), .blk_req(blk_req),
        .blk_waddr(blk_waddr), .blk_wdata(blk_wdata), .blk_gnt(blk_gnt_b),
        .vram_we(vram_we_b), .vram_write_address(vram_write_address_b),
        .vram_write_data(vram_write_data_b), .busy(busy_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc(input logic we, input logic [15:0] a, input logic [7:0] d, input logic req);
        cpu_we            = we;
        cpu_write_address = a;
        cpu_write_data    = d;
        blk_req           = req;
        blk_waddr         = ba;
        blk_wdata         = ba[7:0] ^ 8'h55;
        #1;
    endtask

    task automatic step();
        logic g;
        g = use_b ? blk_gnt_b : blk_gnt;
        @(posedge clk);
        #1;
        if (g)
            ba = ba + 16'd1;
    endtask

    // Urgent drain on the default instance, cycles 0..8
    logic [8:0]  u_we  = 9'b000000111;
    logic [8:0]  u_req = 9'b000111111;
    logic [8:0]  u_g   = 9'b000110111;
    logic [8:0]  u_vwe = 9'b011111111;
    logic [15:0] u_addr [9] = '{16'h2000, 16'h2001, 16'h2002, 16'h0300, 16'h2003,
                                16'h2004, 16'h0301, 16'h0302, 16'h0302};
    logic [7:0]  u_data [9] = '{8'h55, 8'h54, 8'h57, 8'hA0, 8'h56, 8'h51, 8'hA1, 8'hA2, 8'hA2};

    // Overflow on the URGENT=DEPTH instance, cycles 0..9
    logic [9:0]  o_we  = 10'b0000011111;
    logic [9:0]  o_req = 10'b0000111111;
    logic [9:0]  o_g   = 10'b0000101111;
    logic [9:0]  o_vwe = 10'b0111111111;
    logic [15:0] o_addr [10] = '{16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h0400,
                                 16'h3004, 16'h0401, 16'h0402, 16'h0403, 16'h0403};
    logic [7:0]  o_data [10] = '{8'h55, 8'h54, 8'h57, 8'h56, 8'hB0, 8'h51, 8'hB1, 8'hB2,
                                 8'hB3, 8'hB3};

    initial begin
        use_b = 1'b0;
        ba    = 16'h0;
        hits  = 0;

        #1 rst = 1'b0;
        #1;
        chk("rst_vram_we", 32'(vram_we), 0);
        chk("rst_addr", 32'(vram_write_address), 0);
        chk("rst_data", 32'(vram_write_data), 0);
        chk("rst_blk_gnt", 32'(blk_gnt), 0);
        chk("rst_cpu_full", 32'(cpu_full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // single CPU write into an idle arbiter
        cyc(1'b1, 16'h0105, 8'h41, 1'b0);
        chk("idle_blk_gnt", 32'(blk_gnt), 0);
        step();
        chk("idle_we_n1", 32'(vram_we), 0);
        chk("idle_busy_n1", 32'(busy), 1);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        step();
        chk("idle_we_n2", 32'(vram_we), 1);
        chk("idle_addr", 32'(vram_write_address), 32'h0105);
        chk("idle_data", 32'(vram_write_data), 32'h41);
        chk("idle_busy_n2", 32'(busy), 1);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        step();
        chk("idle_we_n3", 32'(vram_we), 0);
        chk("idle_busy_n3", 32'(busy), 0);
        chk("idle_addr_hold", 32'(vram_write_address), 32'h0105);

        // bulk-only stream
        ba = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 16'h0, 8'h0, 1'b1);
            chk("bulk_gnt", 32'(blk_gnt), 1);
            step();
            chk("bulk_we", 32'(vram_we), 1);
            chk("bulk_addr", 32'(vram_write_address), 32'(i));
            chk("bulk_data", 32'(vram_write_data), 32'(i[7:0] ^ 8'h55));
        end
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        chk("bulk_gnt_noreq", 32'(blk_gnt), 0);
        step();
        chk("bulk_we_end", 32'(vram_we), 0);
        chk("bulk_busy_end", 32'(busy), 0);

        // burst fairness: 8 bulk grants with CPU pending, then one CPU slot
        ba = 16'h1000;
        for (int c = 0; c < 12; c++) begin
            cyc(c == 0, 16'h0200, 8'h5A, 1'b1);
            chk("fair_gnt", 32'(blk_gnt), (c != 9) ? 1 : 0);
            exp_a = (c == 9) ? 16'h0200 : ba;
            step();
            chk("fair_we", 32'(vram_we), 1);
            chk("fair_addr", 32'(vram_write_address), 32'(exp_a));
            if (c == 9)
                chk("fair_cpu_data", 32'(vram_write_data), 32'h5A);
            if (vram_write_address == 16'h0200)
                hits++;
        end
        chk("fair_cpu_once", 32'(hits), 1);
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        step();
        chk("fair_we_end", 32'(vram_we), 0);

        // urgent threshold
        ba = 16'h2000;
        for (int c = 0; c < 9; c++) begin
            cyc(u_we[c[3:0]], 16'h0300 + c[15:0], 8'hA0 + c[7:0], u_req[c[3:0]]);
            chk("urg_gnt", 32'(blk_gnt), 32'(u_g[c[3:0]]));
            step();
            chk("urg_we", 32'(vram_we), 32'(u_vwe[c[3:0]]));
            chk("urg_addr", 32'(vram_write_address), 32'(u_addr[c[3:0]]));
            chk("urg_data", 32'(vram_write_data), 32'(u_data[c[3:0]]));
        end
        chk("urg_busy_end", 32'(busy), 0);

        // overflow on the URGENT=DEPTH instance, starting from a clean reset
        cyc(1'b0, 16'h0, 8'h0, 1'b0);
        rst = 1'b0;
        #2 rst = 1'b1;
        use_b = 1'b1;
        ba    = 16'h3000;
        for (int c = 0; c < 10; c++) begin
            cyc(o_we[c[3:0]], 16'h0400 + c[15:0], 8'hB0 + c[7:0], o_req[c[3:0]]);
            chk("ovf_gnt", 32'(blk_gnt_b), 32'(o_g[c[3:0]]));
            step();
            chk("ovf_we", 32'(vram_we_b), 32'(o_vwe[c[3:0]]));
            chk("ovf_addr", 32'(vram_write_address_b), 32'(o_addr[c[3:0]]));
            chk("ovf_data", 32'(vram_write_data_b), 32'(o_data[c[3:0]]));
            chk("ovf_full", 32'(cpu_full_b), (c == 3) ? 1 : 0);
            chk("ovf_sticky", 32'(overflow_b), (c >= 4) ? 1 : 0);
        end
        use_b = 1'b0;

        // asynchronous reset with two entries queued in the default instance
        ba = 16'h4000;
        cyc(1'b1, 16'h0500, 8'hC0, 1'b1);
        step();
        cyc(1'b1, 16'h0501, 8'hC1, 1'b1);
        step();
        chk("ar_pre_we", 32'(vram_we), 1);
        chk("ar_pre_addr", 32'(vram_write_address), 32'h4001);
        chk("ar_pre_ovf_b", 32'(overflow_b), 1);
        cpu_we = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_we", 32'(vram_we), 0);
        chk("ar_addr", 32'(vram_write_address), 0);
        chk("ar_data", 32'(vram_write_data), 0);
        chk("ar_blk_gnt", 32'(blk_gnt), 0);
        chk("ar_cpu_full", 32'(cpu_full), 0);
        chk("ar_ovf_b", 32'(overflow_b), 0);
        chk("ar_we_b", 32'(vram_we_b), 0);
        blk_req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        chk("ar_post_we1", 32'(vram_we), 0);
        chk("ar_post_busy", 32'(busy), 0);
        step();
        chk("ar_post_we2", 32'(vram_we), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Sequences the single VRAM write port between two requesters: posted CPU character writes and a bulk engine (clear engine, later scroll) that streams many writes.
- CPU writes are buffered in a small FIFO so they are never blocked by a long clear.
- The bulk stream gets bounded bursts; the CPU is guaranteed service slots.
- Sits between the CPU bus / clear engine and the VRAM write port inside the GPU controller. It replaces the combinational busy-mux.

Parameters:
- DEPTH, 4, CPU write FIFO entries (power of 2, >=2).
- BURST_MAX, 8, max consecutive bulk grants while CPU writes are pending.
- URGENT, 3, FIFO occupancy at or above which the CPU wins every cycle (1..DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_we  in  1  CPU write strobe, one write per cycle high.
- cpu_write_address  in  16  CPU write address.
- cpu_write_data  in  8  CPU write data.
- cpu_full  out  1  FIFO full; writes presented while high are dropped.
- blk_req  in  1  bulk engine has a write pending.
- blk_waddr  in  16  bulk write address, held while blk_req=1 and blk_gnt=0.
- blk_wdata  in  8  bulk write data, held likewise.
- blk_gnt  out  1  bulk write accepted this cycle; engine advances on it.
- vram_we  out  1  VRAM write enable.
- vram_write_address  out  16  VRAM write address.
- vram_write_data  out  8  VRAM write data.
- busy  out  1  FIFO non-empty OR blk_req OR vram_we.
- overflow  out  1  sticky: a CPU write was dropped.

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, state=IDLE, burst_cnt=0; vram_we=0, address/data=0; overflow=0, blk_gnt=0.
- FIFO:
  - Push when cpu_we && count!=DEPTH.
  - cpu_we with count==DEPTH: write dropped, overflow set until reset. A same-cycle pop does not make room.
  - cpu_full = (count==DEPTH), driven from registered count.
  - Pop on CPU grant. Push+pop in the same cycle: count unchanged, order preserved.
- Arbitration, evaluated every cycle on registered state plus current inputs; cpu_pend = count!=0:
  - Neither pending: no grant.
  - Only one pending: grant it.
  - Both pending: CPU wins if count>=URGENT or burst_cnt==BURST_MAX; otherwise bulk wins.
- burst_cnt:
  - Increments on a bulk grant while cpu_pend, saturating at BURST_MAX.
  - Clears on a CPU grant, or on any cycle without a bulk grant.
  - A bulk grant with cpu_pend=0 leaves burst_cnt at 0.
- blk_gnt is combinational, same cycle as blk_req. It is never asserted with blk_req=0.
- State register (reflects the last grant): IDLE (none), BULK, CPU.
  - Next state = owner of this cycle's grant, else IDLE.
  - Used for debug and busy; arbitration is defined only by the rules above.
- Output stage is registered with 1-cycle latency:
  - Grant in cycle N gives vram_we=1 with the granted address/data in cycle N+1.
  - No grant: vram_we=0; address/data hold their previous values.
- Ordering: CPU writes reach VRAM in push order. Bulk writes reach VRAM in grant order.
- Latency: CPU write to an empty FIFO with no bulk request:
  - Push in cycle N, grant in cycle N+1, vram_we in cycle N+2.
  - Worst case with bulk active: BURST_MAX+1 cycles per CPU entry.
- Reset mid-operation: FIFO contents are discarded and the output stage clears immediately. The bulk engine sees blk_gnt=0 and must restart itself.
- Throughput: at most one VRAM write per cycle, and every cycle with any requester pending produces a write.

Test Plan:
- Idle CPU: cpu_we=1 for 1 cycle, addr=0x0105, data=0x41, blk_req=0 -> vram_we=1 two cycles later with 0x0105/0x41; busy falls the cycle after.
- Bulk only: blk_req=1 for 20 cycles with incrementing addr from 0x0000 -> blk_gnt=1 for all 20 cycles; vram_we stream of 0x0000..0x0013, one cycle delayed, no gaps.
- Burst fairness: blk_req held high, then one CPU write (addr 0x0200, data 0x5A) -> 8 bulk grants, then 1 CPU grant with blk_gnt=0 in that cycle, then bulk resumes; 0x0200/0x5A appears exactly once.
- Urgent: blk_req high, 3 back-to-back CPU writes -> once count=3, CPU is granted on consecutive cycles until count=2; bulk then takes the port.
- Overflow: blk_req high, BURST_MAX not yet reached, 5 back-to-back CPU writes with DEPTH=4 -> the 4th push asserts cpu_full (urgent path drains); a dropped write sets overflow=1; accepted writes appear in order.
- Async reset mid-burst: rst=0 between clock edges while FIFO holds 2 entries -> vram_we=0, blk_gnt=0, cpu_full=0, overflow=0 immediately; after release, no stale FIFO entries are written.
